// File: rtl/coherence_pkg.sv
// Shared encodings for the two-cache MSI coherence system: bus ops, MSI line states and
// the bus controller's state codes. Pure types, no logic.
// Imported by the bus controller and by the cache-side state machines.
package coherence_pkg;

    // Snooping-bus transaction encodings (BUS_NONE means no request / idle bus)
    typedef enum logic [1:0] {
        BUS_NONE = 2'b00,
        BUS_RM   = 2'b01,
        BUS_WM   = 2'b10,
        BUS_INV  = 2'b11
    } bus_op_e;

    // MSI line states used by the cache controllers
    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_state_e;

    // Bus controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BCAST  = 3'd1,
        ST_SNOOP  = 3'd2,
        ST_WB     = 3'd3,
        ST_MEM_RD = 3'd4,
        ST_DONE   = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: one-hot winner among eligible requests.
// Latency: combinational. Backpressure: none, the caller decides when the result is used.
// Ports: req (eligible requests), ptr (index preferred on a tie), win (one-hot winner or 0).
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        // Only a tie needs the pointer; a single request wins outright
        if (req == 2'b11) begin
            win = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping-bus controller: arbitrates two cache controllers, broadcasts the granted op,
// collects the snoop write-back and sequences shared memory; a snooped M copy aborts the read.
// Latency from IDLE decision: INV 3, write-back path 4, memory path 3+MEM_LATENCY cycles.
// Backpressure: requesters hold req until their done pulse; one transaction in flight at a time.
// Ports: req/op0/op1/addr0/addr1 requester side; grant, bus_valid/op/addr/src broadcast;
//        snoop_wb/snoop_data snoop response; mem_* memory port; rsp_data/rsp_fwd/done completion.
module coherence_bus_ctrl
    import coherence_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        grant,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_src,
    input  logic [1:0]        snoop_wb,
    input  logic [DATA_W-1:0] snoop_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fwd,
    output logic [1:0]        done
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    ctrl_state_e       state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              src_q;
    logic              rr_ptr;
    logic [CNT_W-1:0]  lat_cnt;

    logic [1:0] eligible;
    logic [1:0] win;

    assign eligible[0] = req[0] && (op0 != BUS_NONE);
    assign eligible[1] = req[1] && (op1 != BUS_NONE);

    rr_arbiter2 u_arb (
        .req (eligible),
        .ptr (rr_ptr),
        .win (win)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= BUS_NONE;
            addr_q    <= '0;
            src_q     <= 1'b0;
            rr_ptr    <= 1'b0;
            lat_cnt   <= '0;
            grant     <= 2'b00;
            bus_valid <= 1'b0;
            bus_op    <= BUS_NONE;
            bus_addr  <= '0;
            bus_src   <= 1'b0;
            mem_addr  <= '0;
            mem_wren  <= 1'b0;
            mem_wdata <= '0;
            rsp_data  <= '0;
            rsp_fwd   <= 1'b0;
            done      <= 2'b00;
        end else begin
            // Strobes are single-cycle; bus_addr/bus_src deliberately hold their last value
            bus_valid <= 1'b0;
            bus_op    <= BUS_NONE;
            mem_wren  <= 1'b0;
            done      <= 2'b00;

            case (state)
                ST_IDLE: begin
                    if (eligible != 2'b00) begin
                        // Latch the winner's op/addr so later input changes cannot disturb it
                        src_q     <= win[1];
                        op_q      <= win[1] ? op1 : op0;
                        addr_q    <= win[1] ? addr1 : addr0;
                        grant     <= win;
                        bus_valid <= 1'b1;
                        bus_op    <= win[1] ? op1 : op0;
                        bus_addr  <= win[1] ? addr1 : addr0;
                        bus_src   <= win[1];
                        state     <= ST_BCAST;
                    end
                end

                ST_BCAST: begin
                    state <= ST_SNOOP;
                end

                ST_SNOOP: begin
                    if (op_q == BUS_INV) begin
                        done  <= src_q ? 2'b10 : 2'b01;
                        state <= ST_DONE;
                    end else if (snoop_wb[~src_q]) begin
                        // Only the other cache can own the line; the source's own bit is ignored.
                        // The responder presents its write-back data alongside snoop_wb.
                        mem_wren  <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= snoop_data;
                        rsp_data  <= snoop_data;
                        rsp_fwd   <= 1'b1;
                        state     <= ST_WB;
                    end else begin
                        mem_addr <= addr_q;
                        lat_cnt  <= CNT_W'(MEM_LATENCY - 1);
                        state    <= ST_MEM_RD;
                    end
                end

                ST_WB: begin
                    done  <= src_q ? 2'b10 : 2'b01;
                    state <= ST_DONE;
                end

                ST_MEM_RD: begin
                    if (lat_cnt == '0) begin
                        rsp_data <= mem_rdata;
                        rsp_fwd  <= 1'b0;
                        done     <= src_q ? 2'b10 : 2'b01;
                        state    <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    grant  <= 2'b00;
                    rr_ptr <= ~src_q;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
module tb_coherence_bus_ctrl;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int LAT    = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req = 2'b00;
    logic [1:0]        op0 = 2'b00;
    logic [1:0]        op1 = 2'b00;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [1:0]        grant;
    logic              bus_valid;
    logic [1:0]        bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_src;
    logic [1:0]        snoop_wb = 2'b00;
    logic [DATA_W-1:0] snoop_data = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_fwd;
    logic [1:0]        done;

    coherence_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .req(req), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .grant(grant), .bus_valid(bus_valid),
        .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src),
        .snoop_wb(snoop_wb), .snoop_data(snoop_data), .mem_addr(mem_addr),
        .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_data(rsp_data), .rsp_fwd(rsp_fwd), .done(done)
    );

    always #5 clock = ~clock;

    // Shared memory device: registered read, write on mem_wren
    logic [DATA_W-1:0] mem     [0:7];
    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:7];
    logic              ptr_m = 1'b0;
    logic [DATA_W-1:0] rsp_m = '0;
    logic              fwd_m = 1'b0;

    always @(posedge clock) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_grant"}, grant, 0);
        check({pfx, "_bus_valid"}, bus_valid, 0);
        check({pfx, "_bus_op"}, bus_op, 0);
        check({pfx, "_bus_addr"}, bus_addr, 0);
        check({pfx, "_bus_src"}, bus_src, 0);
        check({pfx, "_mem_addr"}, mem_addr, 0);
        check({pfx, "_mem_wren"}, mem_wren, 0);
        check({pfx, "_mem_wdata"}, mem_wdata, 0);
        check({pfx, "_rsp_data"}, rsp_data, 0);
        check({pfx, "_rsp_fwd"}, rsp_fwd, 0);
        check({pfx, "_done"}, done, 0);
    endtask

    // Called just after a rising edge with the controller idle (cycle 0).
    // Returns just after the rising edge that starts the next idle cycle.
    task automatic run_txn(input logic [1:0] r, input logic [1:0] o0, input logic [2:0] a0,
                           input logic [1:0] o1, input logic [2:0] a1,
                           input logic [1:0] swb, input logic [7:0] sd, input bit scramble);
        logic [1:0] elig;
        int         src;
        logic [1:0] op;
        logic [2:0] a;
        logic [1:0] win;
        bit         wb;
        int         len;
        req = r; op0 = o0; addr0 = a0; op1 = o1; addr1 = a1;
        snoop_wb = swb; snoop_data = sd;

        elig[0] = r[0] && (o0 != 2'b00);
        elig[1] = r[1] && (o1 != 2'b00);
        if (elig == 2'b00) begin
            @(posedge clock); #1;
            check("idle_grant", grant, 0);
            check("idle_bus_valid", bus_valid, 0);
            return;
        end

        if (elig == 2'b11) src = ptr_m ? 1 : 0;
        else               src = elig[1] ? 1 : 0;
        op  = (src == 1) ? o1 : o0;
        a   = (src == 1) ? a1 : a0;
        win = (src == 1) ? 2'b10 : 2'b01;
        wb  = (op != 2'b11) && swb[1 - src];
        len = (op == 2'b11) ? 3 : (wb ? 4 : 3 + LAT);

        if (op != 2'b11) begin
            if (wb) begin
                ref_mem[a] = sd;
                rsp_m = sd;
                fwd_m = 1'b1;
            end else begin
                rsp_m = ref_mem[a];
                fwd_m = 1'b0;
            end
        end

        for (int c = 1; c <= len; c++) begin
            @(posedge clock); #1;
            check("grant", grant, win);
            check("bus_valid", bus_valid, (c == 1) ? 1 : 0);
            check("bus_op", bus_op, (c == 1) ? op : 2'b00);
            check("bus_addr", bus_addr, a);
            check("bus_src", bus_src, src);
            check("done", done, (c == len) ? win : 2'b00);
            check("mem_wren", mem_wren, (wb && c == 3) ? 1 : 0);
            if (wb && c == 3) begin
                check("wb_mem_addr", mem_addr, a);
                check("wb_mem_wdata", mem_wdata, sd);
            end
            if (!wb && op != 2'b11 && c >= 3 && c < len)
                check("rd_mem_addr", mem_addr, a);
            if (c == len) begin
                check("rsp_data", rsp_data, rsp_m);
                check("rsp_fwd", rsp_fwd, fwd_m);
            end
            if (scramble && c == 2) begin
                // Inputs change mid-flight; the latched transaction must be unaffected
                req   = 2'($urandom_range(0, 3));
                op0   = 2'($urandom_range(0, 3));
                op1   = 2'($urandom_range(0, 3));
                addr0 = 3'($urandom_range(0, 7));
                addr1 = 3'($urandom_range(0, 7));
            end
        end
        ptr_m = (src == 0) ? 1'b1 : 1'b0;

        @(posedge clock); #1;
        check("post_grant", grant, 0);
        check("post_done", done, 0);
    endtask

    // Start a RM from requester 0 and hit reset in its first WB / MEM_RD cycle.
    task automatic abort_txn(input logic [1:0] swb, input string pfx);
        req = 2'b01; op0 = 2'b01; addr0 = 3'd1; op1 = 2'b00;
        snoop_wb = swb; snoop_data = 8'h77;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        #1;
        check_reset_vals(pfx);
        @(posedge clock); #1;
        check({pfx, "_held_done"}, done, 0);
        check({pfx, "_held_wren"}, mem_wren, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        ptr_m = 1'b0;
        rsp_m = '0;
        fwd_m = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 8'($urandom_range(0, 255));
            ref_mem[i] = mem[i];
        end
        mem[5] = 8'hA5; ref_mem[5] = 8'hA5;
        mem[6] = 8'h5A; ref_mem[6] = 8'h5A;

        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;

        // Directed: RM via memory, WM with remote write-back, INV
        run_txn(2'b01, 2'b01, 3'd5, 2'b00, 3'd0, 2'b00, 8'h00, 1'b0);
        run_txn(2'b10, 2'b00, 3'd0, 2'b10, 3'd3, 2'b01, 8'h3C, 1'b0);
        run_txn(2'b01, 2'b11, 3'd2, 2'b00, 3'd0, 2'b00, 8'h00, 1'b0);
        // Source's own snoop bit ignored
        run_txn(2'b01, 2'b01, 3'd6, 2'b00, 3'd0, 2'b01, 8'hEE, 1'b0);
        // Both requesting continuously: grants alternate
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, 2'b11, 3'(i), 2'b11, 3'(7 - i), 2'b00, 8'h00, 1'b0);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            run_txn(2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
        end

        // Reset during MEM_RD, then during WB; pointer forced to 1 beforehand
        run_txn(2'b01, 2'b11, 3'd0, 2'b00, 3'd0, 2'b00, 8'h00, 1'b0);
        abort_txn(2'b00, "rst_memrd");
        run_txn(2'b11, 2'b11, 3'd4, 2'b11, 3'd5, 2'b00, 8'h00, 1'b0);
        run_txn(2'b01, 2'b11, 3'd0, 2'b00, 3'd0, 2'b00, 8'h00, 1'b0);
        abort_txn(2'b10, "rst_wb");
        run_txn(2'b11, 2'b11, 3'd4, 2'b11, 3'd5, 2'b00, 8'h00, 1'b0);
        // Memory must be untouched by the aborted write-back
        run_txn(2'b01, 2'b01, 3'd1, 2'b00, 3'd0, 2'b00, 8'h00, 1'b0);

        req = 2'b00;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
